fetch_line_server: RTL and testbench
====================================

FETCH_LINE_SERVER -- requirements
Module: fetch_line_server

Interface
REQ-001 SHALL have parameter PA_BITS, default 34: physical address width.
REQ-002 SHALL have parameter LINELEN, default 512: line width in bits.
REQ-003 SHALL have parameter BEATLEN, default 64: bus beat width in bits; BEATS = LINELEN/BEATLEN (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port ReqValid, input, 1: fetch-buffer line request valid.
REQ-007 SHALL have port ReqReady, output, 1: request accepted when ReqValid & ReqReady.
REQ-008 SHALL have port ReqPAdr, input, PA_BITS: request byte address (any alignment).
REQ-009 SHALL have port RspValid, output, 1: line response valid.
REQ-010 SHALL have port RspReady, input, 1: consumer takes response when RspValid & RspReady.
REQ-011 SHALL have port RspLine, output, LINELEN: line data, beat 0 in bits [BEATLEN-1:0].
REQ-012 SHALL have port RspPAdr, output, PA_BITS: line-aligned address of RspLine.
REQ-013 SHALL have port RspErr, output, 1: any beat of the line returned BusErr.
REQ-014 SHALL have port FlushStage, input, 1: abort pending request/response.
REQ-015 SHALL have port BusReq, output, 1: burst request to memory.
REQ-016 SHALL have port BusAdr, output, PA_BITS: burst start address, line-aligned.
REQ-017 SHALL have port BusAck, input, 1: memory accepted burst request.
REQ-018 SHALL have port BusBeatValid, input, 1: one data beat present.
REQ-019 SHALL have port BusRData, input, BEATLEN: beat data.
REQ-020 SHALL have port BusErr, input, 1: error on current beat (qualified by BusBeatValid).

Function
REQ-021 SHALL implement states IDLE, ADDR, BEATS, RESP, DRAIN.
REQ-022 IDLE: ReqReady=1; on accept, latch line-aligned ReqPAdr (low log2(LINELEN/8) bits zeroed) and go to ADDR.
REQ-023 ADDR: BusReq=1, BusAdr=latched address; on BusAck go to BEATS with beat counter=0.
REQ-024 BEATS: each BusBeatValid writes BusRData to beat slot [counter], ORs BusErr into error flag, increments counter; on beat BEATS-1 go to RESP next cycle.
REQ-025 RESP: RspValid=1 with RspLine/RspPAdr/RspErr stable until handshake; on RspValid & RspReady go to IDLE.
REQ-026 ReqReady SHALL be 0 in every state except IDLE; at most one request outstanding.
REQ-027 Miss latency: RspValid SHALL assert the cycle after the last beat is captured.
REQ-028 BusBeatValid outside BEATS/DRAIN SHALL be ignored.
REQ-029 FlushStage in IDLE/ADDR-before-BusAck: go to IDLE next cycle, BusReq deasserts, no response.
REQ-030 FlushStage in BEATS (or coincident with BusAck in ADDR): go to DRAIN; consume remaining beats; return to IDLE after last beat; no response.
REQ-031 FlushStage in RESP: drop response, go to IDLE; FlushStage has priority over a simultaneous RspReady.
REQ-032 FlushStage in IDLE with ReqValid SHALL NOT accept the request.
REQ-033 Beat counter SHALL be log2(BEATS) bits and wrap to 0 after BEATS-1.

Reset
REQ-034 On reset=0: state IDLE, ReqReady=1, RspValid=0, BusReq=0, BusAdr=0, RspPAdr=0, RspErr=0, counter=0, line valid flag=0; RspLine contents unspecified.
REQ-035 Reset asserted mid-burst SHALL abandon the burst immediately; no drain.

Configuration
REQ-036 Macro FETCH_LINE_SERVER_LASTLINE_HIT_EN: when defined, a completed error-free line is retained with a valid flag; a request whose aligned address matches goes IDLE->RESP directly (response one cycle after accept, no BusReq); FlushStage does not clear the flag, reset does.
REQ-037 Without FETCH_LINE_SERVER_LASTLINE_HIT_EN, every request issues a bus burst; no hit logic present.

Verification
REQ-038 Request 0x0000_1044, BusAck cycle 2, beats 0..7 = 0x10..0x17 -> BusAdr=0x0000_1040, RspValid cycle after beat 7, RspLine beat k = 0x10+k, RspErr=0.
REQ-039 Miss with BusErr on beat 3 only -> RspErr=1, all 8 beats still captured, line not retained for hit.
REQ-040 FlushStage after beat 2 -> DRAIN consumes beats 3..7, no RspValid, ReqReady returns cycle after beat 7.
REQ-041 RspReady held 0 for 5 cycles in RESP -> RspLine/RspPAdr unchanged, ReqReady=0 throughout.
REQ-042 With macro: second request 0x0000_1078 after filling 0x0000_1040 -> RspValid one cycle after accept, BusReq stays 0.
REQ-043 reset=0 during BEATS beat 4 -> all outputs at reset values immediately, later stray beats ignored.

Source files
------------

// File: rtl/fetch_line_server.sv
// Line fetch server: one outstanding fetch-buffer request, filled by a single memory burst.
// Optional FETCH_LINE_SERVER_LASTLINE_HIT_EN retains the last clean line and answers repeat requests without a burst.
module fetch_line_server #(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [PA_BITS-1:0] ReqPAdr,
  output logic               RspValid,
  input  logic               RspReady,
  output logic [LINELEN-1:0] RspLine,
  output logic [PA_BITS-1:0] RspPAdr,
  output logic               RspErr,
  input  logic               FlushStage,
  output logic               BusReq,
  output logic [PA_BITS-1:0] BusAdr,
  input  logic               BusAck,
  input  logic               BusBeatValid,
  input  logic [BEATLEN-1:0] BusRData,
  input  logic               BusErr
);

  localparam int NUM_BEATS = LINELEN / BEATLEN;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int OFS_W     = $clog2(LINELEN / 8);

  typedef enum logic [2:0] {IDLE, ADDR, BEATS, RESP, DRAIN} state_t;

  state_t             state, state_next;
  logic [PA_BITS-1:0] addr_q;
  logic [LINELEN-1:0] line_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               accept;
  logic               last_beat;
  logic               hit;
  logic [PA_BITS-1:0] req_line_adr;

  assign req_line_adr = ReqPAdr & ~{{(PA_BITS-OFS_W){1'b0}}, {OFS_W{1'b1}}};
  assign accept       = (state == IDLE) && ReqValid && !FlushStage;
  assign last_beat    = BusBeatValid && (&cnt_q);

`ifdef FETCH_LINE_SERVER_LASTLINE_HIT_EN
  logic line_valid_q;

  // addr_q still names the retained line until the next miss is accepted
  assign hit = line_valid_q && (addr_q == req_line_adr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      line_valid_q <= 1'b0;
    else if (accept && !hit)
      line_valid_q <= 1'b0;
    else if (state == BEATS && last_beat && !FlushStage && !(err_q || BusErr))
      line_valid_q <= 1'b1;
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = hit ? RESP : ADDR;
      ADDR: begin
        if (BusAck)          state_next = FlushStage ? DRAIN : BEATS;
        else if (FlushStage) state_next = IDLE;
      end
      BEATS: begin
        if (last_beat)       state_next = FlushStage ? IDLE : RESP;
        else if (FlushStage) state_next = DRAIN;
      end
      RESP:  if (FlushStage || RspReady) state_next = IDLE;
      DRAIN: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q <= req_line_adr;
        err_q  <= 1'b0;
      end
      if (state == ADDR && BusAck) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if ((state == BEATS || state == DRAIN) && BusBeatValid) begin
        cnt_q <= cnt_q + 1'b1;
        if (state == BEATS)
          err_q <= err_q | BusErr;
      end
    end
  end

  // Line storage carries no reset; its contents only matter once a burst has filled it
  always_ff @(posedge clk) begin
    if (state == BEATS && BusBeatValid) begin
      for (int k = 0; k < NUM_BEATS; k++) begin
        if (cnt_q == CNT_W'(k))
          line_q[k*BEATLEN +: BEATLEN] <= BusRData;
      end
    end
  end

  assign ReqReady = (state == IDLE);
  assign RspValid = (state == RESP);
  assign BusReq   = (state == ADDR);
  assign BusAdr   = addr_q;
  assign RspPAdr  = addr_q;
  assign RspErr   = err_q;
  assign RspLine  = line_q;

endmodule

// File: tb/tb_fetch_line_server.sv
// Testbench for fetch_line_server: transaction-level expectation model checked every cycle,
// plus literal pins; follows FETCH_LINE_SERVER_LASTLINE_HIT_EN when it is defined.
module tb_fetch_line_server;

  localparam int PA_BITS = 34;
  localparam int LINELEN = 512;
  localparam int BEATLEN = 64;
  localparam int NB      = 8;
`ifdef FETCH_LINE_SERVER_LASTLINE_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               ReqValid = 1'b0, RspReady = 1'b0, FlushStage = 1'b0;
  logic               BusAck = 1'b0, BusBeatValid = 1'b0, BusErr = 1'b0;
  logic [PA_BITS-1:0] ReqPAdr = '0;
  logic [BEATLEN-1:0] BusRData = '0;
  logic               ReqReady, RspValid, RspErr, BusReq;
  logic [LINELEN-1:0] RspLine;
  logic [PA_BITS-1:0] RspPAdr, BusAdr;

  always #5 clk = ~clk;

  fetch_line_server #(.PA_BITS(PA_BITS), .LINELEN(LINELEN), .BEATLEN(BEATLEN)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqPAdr(ReqPAdr),
    .RspValid(RspValid), .RspReady(RspReady), .RspLine(RspLine), .RspPAdr(RspPAdr), .RspErr(RspErr),
    .FlushStage(FlushStage),
    .BusReq(BusReq), .BusAdr(BusAdr), .BusAck(BusAck),
    .BusBeatValid(BusBeatValid), .BusRData(BusRData), .BusErr(BusErr)
  );

  int checks = 0;
  int failures = 0;

  logic               exp_req_ready, exp_rsp_valid, exp_bus_req, exp_rsp_err;
  logic [PA_BITS-1:0] exp_adr;
  logic [LINELEN-1:0] exp_line;
  bit                 ret_valid = 1'b0;
  logic [PA_BITS-1:0] ret_adr = '0;
  logic [LINELEN-1:0] ret_line = '0;
  logic [PA_BITS-1:0] seen_adr;

  task automatic checkOutput(input string name, input logic [LINELEN-1:0] act, input logic [LINELEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ReqReady", ReqReady, exp_req_ready);
    checkOutput("RspValid", RspValid, exp_rsp_valid);
    checkOutput("BusReq", BusReq, exp_bus_req);
    if (exp_bus_req) checkOutput("BusAdr", BusAdr, exp_adr);
    if (exp_rsp_valid) begin
      checkOutput("RspPAdr", RspPAdr, exp_adr);
      checkOutput("RspLine", RspLine, exp_line);
      checkOutput("RspErr", RspErr, exp_rsp_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    exp_req_ready = 1'b1;
    exp_rsp_valid = 1'b0;
    exp_bus_req   = 1'b0;
  endtask

  // One request; flush_after: -1 none, -2 with BusAck, k>=0 in the idle cycle after beat k
  task automatic applyStimulus(input logic [PA_BITS-1:0] adr, input int ack_delay, input logic [7:0] err_mask,
                               input int flush_after, input logic [7:0] base);
    logic [PA_BITS-1:0] al;
    logic [LINELEN-1:0] line;
    bit err;
    al = adr & ~PA_BITS'(63);
    seen_adr = '0;
    ReqValid = 1'b1;
    ReqPAdr  = adr;
    tick();
    ReqValid = 1'b0;
    exp_req_ready = 1'b0;
    exp_adr = al;
    if (HIT_EN && ret_valid && ret_adr == al) begin
      exp_rsp_valid = 1'b1;
      exp_line      = ret_line;
      exp_rsp_err   = 1'b0;
      return;
    end
    ret_valid   = 1'b0;
    exp_bus_req = 1'b1;
    seen_adr    = BusAdr;
    repeat (ack_delay) tick();
    BusAck     = 1'b1;
    FlushStage = (flush_after == -2);
    tick();
    BusAck      = 1'b0;
    FlushStage  = 1'b0;
    exp_bus_req = 1'b0;
    line = '0;
    err  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      BusBeatValid = 1'b1;
      BusRData     = BEATLEN'(base + 8'(k));
      BusErr       = err_mask[k];
      line[k*BEATLEN +: BEATLEN] = BusRData;
      err |= err_mask[k];
      tick();
      BusBeatValid = 1'b0;
      BusErr       = 1'b0;
      if (k == flush_after) begin
        FlushStage = 1'b1;
        tick();
        FlushStage = 1'b0;
      end
    end
    if (flush_after != -1) begin
      setIdle();
    end else begin
      exp_rsp_valid = 1'b1;
      exp_line      = line;
      exp_rsp_err   = err;
      if (!err) begin
        ret_valid = 1'b1;
        ret_adr   = al;
        ret_line  = line;
      end
    end
  endtask

  task automatic respond(input int wait_cycles);
    repeat (wait_cycles) tick();
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    setIdle();
  endtask

  initial begin
    setIdle();
    exp_adr = '0; exp_line = '0; exp_rsp_err = 1'b0;
    #2;
    checkOutput("reset ReqReady", ReqReady, 1'b1);
    checkOutput("reset BusAdr", BusAdr, '0);
    checkOutput("reset RspPAdr", RspPAdr, '0);
    checkOutput("reset RspErr", RspErr, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();

    applyStimulus(34'h0_0000_1044, 1, 8'h00, -1, 8'h10);
    checkOutput("basic BusAdr", seen_adr, 34'h0_0000_1040);
    checkOutput("basic RspPAdr", RspPAdr, 34'h0_0000_1040);
    for (int k = 0; k < NB; k++)
      checkOutput("basic beat", RspLine[k*BEATLEN +: BEATLEN], BEATLEN'(16 + k));
    checkOutput("basic RspErr", RspErr, 1'b0);
    respond(0);

    applyStimulus(34'h0_0000_2000, 0, 8'h00, -1, 8'h20);
    respond(5);

    applyStimulus(34'h0_0000_3008, 2, 8'h08, -1, 8'h30);
    checkOutput("err RspErr", RspErr, 1'b1);
    checkOutput("err beat7", RspLine[7*BEATLEN +: BEATLEN], 64'h37);
    respond(0);
    applyStimulus(34'h0_0000_3000, 0, 8'h00, -1, 8'h40);
    checkOutput("err refetch beat0", RspLine[BEATLEN-1:0], 64'h40);
    respond(1);

    applyStimulus(34'h0_0000_4000, 1, 8'h00, 2, 8'h70);
    tick();
    applyStimulus(34'h0_0000_5000, 0, 8'h00, -2, 8'h78);
    tick();

    ReqValid = 1'b1; ReqPAdr = 34'h0_0000_5100;
    tick();
    ReqValid = 1'b0; ret_valid = 1'b0;
    exp_req_ready = 1'b0; exp_bus_req = 1'b1; exp_adr = 34'h0_0000_5100;
    tick();
    FlushStage = 1'b1;
    tick();
    FlushStage = 1'b0;
    setIdle();

    FlushStage = 1'b1; ReqValid = 1'b1; ReqPAdr = 34'h0_0000_5200;
    tick(); tick();
    FlushStage = 1'b0; ReqValid = 1'b0;
    BusBeatValid = 1'b1; BusRData = 64'hdead;
    tick(); tick();
    BusBeatValid = 1'b0;
    tick();

    applyStimulus(34'h0_0000_6000, 0, 8'h00, -1, 8'h80);
    tick();
    FlushStage = 1'b1; RspReady = 1'b1;
    tick();
    FlushStage = 1'b0; RspReady = 1'b0;
    setIdle();
    applyStimulus(34'h0_0000_6010, 0, 8'h00, -1, 8'h90);
    checkOutput("after flush beat0", RspLine[BEATLEN-1:0], HIT_EN ? 64'h80 : 64'h90);
    respond(0);

    applyStimulus(34'h0_0000_1040, 0, 8'h00, -1, 8'h50);
    respond(0);
    applyStimulus(34'h0_0000_1078, 0, 8'h00, -1, 8'h60);
    checkOutput("repeat beat0", RspLine[BEATLEN-1:0], HIT_EN ? 64'h50 : 64'h60);
    respond(2);

    ReqValid = 1'b1; ReqPAdr = 34'h0_0000_7000;
    tick();
    ReqValid = 1'b0; ret_valid = 1'b0;
    exp_req_ready = 1'b0; exp_bus_req = 1'b1; exp_adr = 34'h0_0000_7000;
    BusAck = 1'b1;
    tick();
    BusAck = 1'b0; exp_bus_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      BusBeatValid = 1'b1; BusRData = BEATLEN'(k);
      tick();
    end
    BusRData = 64'h4;
    reset = 1'b0;
    #1;
    setIdle();
    checkOutput("midreset ReqReady", ReqReady, 1'b1);
    checkOutput("midreset RspValid", RspValid, 1'b0);
    checkOutput("midreset BusReq", BusReq, 1'b0);
    checkOutput("midreset BusAdr", BusAdr, '0);
    checkOutput("midreset RspPAdr", RspPAdr, '0);
    checkOutput("midreset RspErr", RspErr, 1'b0);
    tick();
    reset = 1'b1;
    for (int k = 5; k < NB; k++) begin
      BusRData = BEATLEN'(k);
      tick();
    end
    BusBeatValid = 1'b0;
    tick();
    applyStimulus(34'h0_0000_1040, 0, 8'h00, -1, 8'ha0);
    checkOutput("post reset beat0", RspLine[BEATLEN-1:0], 64'ha0);
    respond(0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
